// File: rtl/xy2_100_tx.sv
// xy2_100_tx: free-running XY2-100 galvo transmitter, one frame every 20 bit periods.
// Captures x/y on a rising edge of send and repeats the last pair when nothing new is pending.
module xy2_100_tx #(
   parameter int CLK_DIV = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tx_en,
   input  logic [15:0] x_coord,
   input  logic [15:0] y_coord,
   input  logic        send,
   output logic        xy2_clk,
   output logic        xy2_sync,
   output logic        xy2_x,
   output logic        xy2_y,
   output logic        busy,
   output logic        frame_start,
   output logic        new_loaded,
   output logic        overrun
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nx;

   logic          send_d, pending, ph, rise, half_end, last, load;
   logic [15:0]   hold_x, hold_y, dat_x, dat_y;
   logic [DW-1:0] div_cnt;
   logic [4:0]    bit_idx, nb;
   logic [19:0]   fr_x, fr_y;

   always_comb begin
      rise     = send & ~send_d;
      half_end = div_cnt == DMAX;
      last     = state == SHIFT && half_end && ph && bit_idx == 5'd19;
      load     = tx_en && (state == IDLE || last);
      state_nx = load ? SHIFT : last ? IDLE : state;
      nb       = bit_idx + 5'd1;
      fr_x     = {3'b001, dat_x, ~^dat_x};
      fr_y     = {3'b001, dat_y, ~^dat_y};
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         send_d      <= 1'b0;
         pending     <= 1'b0;
         hold_x      <= '0;
         hold_y      <= '0;
         dat_x       <= '0;
         dat_y       <= '0;
         div_cnt     <= '0;
         ph          <= 1'b0;
         bit_idx     <= '0;
         xy2_clk     <= 1'b0;
         xy2_sync    <= 1'b0;
         xy2_x       <= 1'b0;
         xy2_y       <= 1'b0;
         busy        <= 1'b0;
         frame_start <= 1'b0;
         new_loaded  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         send_d      <= send;
         frame_start <= 1'b0;
         new_loaded  <= 1'b0;
         overrun     <= 1'b0;
         if (rise && !load) begin
            hold_x  <= x_coord;
            hold_y  <= y_coord;
            pending <= 1'b1;
            overrun <= pending;
         end
         if (load) begin
            // A capture on the load edge bypasses the holding register so no frame goes out stale
            dat_x       <= rise ? x_coord : pending ? hold_x : dat_x;
            dat_y       <= rise ? y_coord : pending ? hold_y : dat_y;
            pending     <= 1'b0;
            new_loaded  <= rise | pending;
            overrun     <= rise & pending;
            frame_start <= 1'b1;
            div_cnt     <= '0;
            ph          <= 1'b0;
            bit_idx     <= '0;
            xy2_clk     <= 1'b1;
            xy2_sync    <= 1'b1;
            xy2_x       <= 1'b0;
            xy2_y       <= 1'b0;
            busy        <= 1'b1;
         end else if (last) begin
            xy2_clk  <= 1'b0;
            xy2_sync <= 1'b0;
            xy2_x    <= 1'b0;
            xy2_y    <= 1'b0;
            busy     <= 1'b0;
         end else if (state == SHIFT) begin
            div_cnt <= half_end ? '0 : div_cnt + 1'b1;
            if (half_end) begin
               ph      <= ~ph;
               xy2_clk <= ph;
               if (ph) begin
                  bit_idx  <= nb;
                  xy2_sync <= nb != 5'd19;
                  xy2_x    <= fr_x[5'd19 - nb];
                  xy2_y    <= fr_y[5'd19 - nb];
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_xy2_100_tx.sv
// tb_xy2_100_tx: directed checks of the XY2-100 transmitter with CLK_DIV=4 (8-cycle bits, 160-cycle frames).
module tb_xy2_100_tx;
   localparam int CLK_DIV = 4;

   logic        clk = 1'b0, reset = 1'b1, tx_en = 1'b0, send = 1'b0;
   logic [15:0] x_coord = '0, y_coord = '0;
   logic        xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_start, new_loaded, overrun;
   int          checks = 0, errors = 0;

   // Hand-computed frames: 001, data MSB first, parity bit making the frame even
   localparam logic [19:0] F1234 = {3'b001, 16'h1234, 1'b0};
   localparam logic [19:0] FABCD = {3'b001, 16'hABCD, 1'b1};
   localparam logic [19:0] F0000 = {3'b001, 16'h0000, 1'b1};
   localparam logic [19:0] F0001 = {3'b001, 16'h0001, 1'b0};

   xy2_100_tx #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .reset(reset), .tx_en(tx_en), .x_coord(x_coord), .y_coord(y_coord), .send(send),
      .xy2_clk(xy2_clk), .xy2_sync(xy2_sync), .xy2_x(xy2_x), .xy2_y(xy2_y), .busy(busy),
      .frame_start(frame_start), .new_loaded(new_loaded), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, got, exp);
      end
   endtask

   // Starts at the negedge following a load edge; ends at the negedge after the next load edge.
   task automatic check_frame(input logic [19:0] ex, input logic [19:0] ey, input logic nl, input string tag);
      for (int n = 0; n < 20; n++)
         for (int c = 0; c < 2 * CLK_DIV; c++) begin
            chk(tag, {1'b0, xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_start, new_loaded},
                {1'b0, c < CLK_DIV, n != 19, ex[19-n], ey[19-n], 1'b1, n == 0 && c == 0, n == 0 && c == 0 && nl});
            @(negedge clk);
         end
   endtask

   task automatic check_idle(input int cycles, input string tag);
      for (int i = 0; i < cycles; i++) begin
         chk(tag, {xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_start, new_loaded, overrun}, 8'h00);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_idle(1, "reset_outputs");
      reset = 1'b0;
      check_idle(5, "idle_after_reset");

      // Single send captured while idle, then enable: first frame carries it
      x_coord = 16'h1234; y_coord = 16'hABCD; send = 1'b1;
      @(negedge clk);
      chk("no_overrun_first", {7'd0, overrun}, 8'h00);
      send = 1'b0; tx_en = 1'b1;
      @(negedge clk);
      check_frame(F1234, FABCD, 1'b1, "single_send");
      check_frame(F1234, FABCD, 1'b0, "repeat");

      // Two captures in one frame: the second overruns and wins
      fork
         check_frame(F1234, FABCD, 1'b0, "frame_during_overrun");
         begin
            repeat (10) @(negedge clk);
            x_coord = 16'h0001; send = 1'b1;
            @(posedge clk); #1;
            chk("overrun_first_capture", {7'd0, overrun}, 8'h00);
            @(negedge clk); send = 1'b0;
            repeat (10) @(negedge clk);
            x_coord = 16'h0000; send = 1'b1;
            @(posedge clk); #1;
            chk("overrun_pulse", {7'd0, overrun}, 8'h01);
            @(negedge clk); send = 1'b0;
            @(negedge clk);
            chk("overrun_one_cycle", {7'd0, overrun}, 8'h00);
         end
      join

      // Rising edge of send exactly on the next load edge goes straight into that frame
      fork
         check_frame(F0000, FABCD, 1'b1, "after_overrun");
         begin
            repeat (159) @(negedge clk);
            x_coord = 16'h0001; send = 1'b1;
         end
      join
      fork
         check_frame(F0001, FABCD, 1'b1, "bypass");
         begin
            @(negedge clk); send = 1'b0;
         end
      join

      // Disable at bit 5: the frame completes, then the line goes quiet
      fork
         check_frame(F0001, FABCD, 1'b0, "bypass_not_pending");
         begin
            repeat (40) @(negedge clk);
            tx_en = 1'b0;
         end
      join
      check_idle(20, "disabled_idle");
      tx_en = 1'b1;
      @(negedge clk);
      check_frame(F0001, FABCD, 1'b0, "restart");

      // Asynchronous reset in the middle of a frame
      repeat (50) @(negedge clk);
      reset = 1'b1; #1;
      chk("reset_mid_frame", {xy2_clk, xy2_sync, xy2_x, xy2_y, busy, frame_start, new_loaded, overrun}, 8'h00);
      tx_en = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check_idle(10, "idle_after_mid_reset");
      tx_en = 1'b1;
      @(negedge clk);
      check_frame(F0000, F0000, 1'b0, "zero_after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xy2_100_tx.md
# xy2_100_tx

Serial XY2-100 galvo transmitter directly downstream of the scan coordinate generator. It captures a new X/Y coordinate pair on each rising edge of `send` (the generator's `xy2_send`) and streams it as XY2-100 frames on separate X and Y data lines, sharing one bit clock and one sync line. Transmission is free-running: while enabled it sends a frame back-to-back every 20 bit periods and repeats the last coordinates when nothing new is pending.

## Interface
- `CLK_DIV`, 25: `clk` cycles per half XY2 bit-clock period. Bit period is 2·CLK_DIV cycles; 25 gives 2 MHz from 100 MHz. Legal range ≥2.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high; clock `clk`.
- `tx_en` input 1: transmit enable, sampled only at frame boundaries and in idle.
- `x_coord` input 16: X position, sampled on a `send` rising edge.
- `y_coord` input 16: Y position, sampled on a `send` rising edge.
- `send` input 1: new-coordinate strobe (level or pulse). Only the rising edge is used.
- `xy2_clk` output 1: XY2 bit clock. High for the first half of each bit, low for the second half.
- `xy2_sync` output 1: frame sync. High for bits 0–18, low for bit 19.
- `xy2_x` output 1: X channel serial data.
- `xy2_y` output 1: Y channel serial data.
- `busy` output 1: high while a frame is on the wire.
- `frame_start` output 1: 1-cycle pulse on every frame load.
- `new_loaded` output 1: 1-cycle pulse when a frame load consumes fresh coordinates.
- `overrun` output 1: 1-cycle pulse when a capture overwrites a still-pending pair.

## Operation
- **Frame format (both channels, MSB first, 20 bits):** C2 C1 C0 = 0 0 1, then D15..D0, then P.
  - P = XOR of the 19 preceding bits, i.e. even parity over the whole frame. This reduces to P = 1 ^ (^D).
- **Capture:** `send_d` registers `send`. A rising edge (`send & ~send_d`) latches x/y into a holding register and sets `pending`.
  - If `pending` was already set, the holding register is overwritten and `overrun` pulses.
- **State machine:**
  - IDLE → LOAD when `tx_en`=1.
  - LOAD → SHIFT (single-edge action).
  - SHIFT → LOAD at the end of bit 19 if `tx_en`=1, otherwise → IDLE.
- **LOAD actions:**
  - Shift registers take the holding value if `pending`; otherwise they keep the previous frame's data.
  - `pending` is cleared; `new_loaded` pulses if `pending` was set.
  - `frame_start` pulses.
- **Capture coincident with LOAD:** the incoming x/y load directly into the shift registers, `pending` stays 0, and `new_loaded` pulses. No frame ever sends stale data in this case.
- **Counters:**
  - `div_cnt` counts 0..CLK_DIV-1 and sets the half-bit phase.
  - `bit_idx` counts 0..19 and wraps to 0 on LOAD.
- **Coordinates** are raw 16-bit values with no arithmetic. After reset the holding register is 0, so the first frame without a prior send transmits 0x0000.

## Timing
- **Reset (asynchronous):** all outputs are 0. `pending`=0, holding=0, shift=0, state=IDLE, `send_d`=0.
- **Reset mid-frame:** outputs drop to 0 immediately. Behaviour after release is the same as after power-up.
- **Load edge L:** all outputs are registered and switch at L.
  - Bit n starts at edge L + n·2·CLK_DIV.
  - `xy2_clk`=1 for CLK_DIV cycles, then 0 for CLK_DIV cycles.
  - Data and sync change only while `xy2_clk` rises; the receiver samples on the falling edge.
- **Frame length:** 40·CLK_DIV cycles. The next load edge is L + 40·CLK_DIV if `tx_en`=1 in the last cycle of bit 19; there is no gap between frames.
- **Frame end with `tx_en`=0:** at L + 40·CLK_DIV all outputs go 0 and `busy`=0.
  - `tx_en` deasserted mid-frame never truncates the frame.
- **Restart from IDLE:** the load edge is the first edge at which `tx_en`=1 is sampled.
- **`busy`:** 1 from L through the final cycle of bit 19.
- **Capture latency:** a rising edge at edge c is transmitted in the frame whose load edge is the first LOAD at or after c (edge c itself counts, via the bypass).

## Test plan
- **Reset:** assert reset mid-frame with CLK_DIV=4 → every output is 0 in the same cycle. After release with `tx_en`=0, outputs stay 0 and `busy`=0.
- **Single send:** CLK_DIV=4, `tx_en`=1, send x=0x1234, y=0xABCD →
  - `new_loaded` pulses at the next load edge.
  - X bits are 001_0001001000110100_0, Y bits are 001_1010101111001101_1.
  - The frame lasts 160 cycles.
  - Sync is low only during bit 19; `xy2_clk` shows 20 high/low pairs of 4 cycles each.
- **Repeat:** no further send → the next frame is identical, `frame_start` pulses, `new_loaded` stays 0.
- **Overrun:** sends of x=0x0001, then x=0x0000, both within one frame →
  - `overrun` pulses on the second capture.
  - The next frame carries X data 0x0000 with P=1.
- **Bypass:** send rising edge exactly on a load edge with x=0x0001 → that frame carries 0x0001 with P=0, and `pending` remains 0 afterwards.
- **Disable:** drop `tx_en` at bit 5 → the frame completes through bit 19, outputs go 0 at L + 40·CLK_DIV, and no further `frame_start` occurs. Raising `tx_en` restarts with a load on the first sampled edge.
